// File: rtl/grey_pkg.sv
// Shared constants, Johnson digit codes, segment patterns and scan state type
// for the Grey digit scanner.
package grey_pkg;

    localparam int unsigned DIGIT_W    = 5;
    localparam int unsigned NUM_DIGITS = 12;

    // 5-bit Johnson (twisted-ring) decimal digit codes
    localparam logic [DIGIT_W-1:0] JC_0 = 5'b00000;
    localparam logic [DIGIT_W-1:0] JC_1 = 5'b00001;
    localparam logic [DIGIT_W-1:0] JC_2 = 5'b00011;
    localparam logic [DIGIT_W-1:0] JC_3 = 5'b00111;
    localparam logic [DIGIT_W-1:0] JC_4 = 5'b01111;
    localparam logic [DIGIT_W-1:0] JC_5 = 5'b11111;
    localparam logic [DIGIT_W-1:0] JC_6 = 5'b11110;
    localparam logic [DIGIT_W-1:0] JC_7 = 5'b11100;
    localparam logic [DIGIT_W-1:0] JC_8 = 5'b11000;
    localparam logic [DIGIT_W-1:0] JC_9 = 5'b10000;

    // Segment patterns {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StSkip,
        StShow,
        StGap
    } scan_state_e;

endpackage

// File: rtl/grey_digit_scan_if.sv
// Digit input / segment output bundle for the Grey digit scanner.
// master: the side supplying enable and digits; slave: the scanner itself.
interface grey_digit_scan_if #(
    parameter int unsigned NUM_DIGITS = 12
);
    logic                      i_en;
    logic [5*NUM_DIGITS-1:0]   i_digits;
    logic [7:0]                o_seg;
    logic [3:0]                o_idx;
    logic                      o_frame;

    modport master (
        output i_en,
        output i_digits,
        input  o_seg,
        input  o_idx,
        input  o_frame
    );

    modport slave (
        input  i_en,
        input  i_digits,
        output o_seg,
        output o_idx,
        output o_frame
    );
endinterface

// File: rtl/grey_seg_dec.sv
// Johnson digit code to 7-segment pattern; any non-Johnson code shows a dash.
module grey_seg_dec
    import grey_pkg::*;
(
    input  logic [DIGIT_W-1:0] code_i,
    output logic [6:0]         seg_o
);

    // Table lookup, invalid codes fall through to the dash pattern
    always_comb begin
        seg_o = SEG_DASH;
        case (code_i)
            JC_0:    seg_o = SEG_0;
            JC_1:    seg_o = SEG_1;
            JC_2:    seg_o = SEG_2;
            JC_3:    seg_o = SEG_3;
            JC_4:    seg_o = SEG_4;
            JC_5:    seg_o = SEG_5;
            JC_6:    seg_o = SEG_6;
            JC_7:    seg_o = SEG_7;
            JC_8:    seg_o = SEG_8;
            JC_9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/grey_digit_scan.sv
// Serialises a snapshot of the Johnson-coded digit vector onto one 7-segment
// output, MSD first, with leading-zero suppression, per-digit dwell and an
// inter-frame blank gap.
// Optional: define GREY_SCAN_DP_EN to light the DP at idx 3/6/9 and during gap.
module grey_digit_scan
    import grey_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = grey_pkg::NUM_DIGITS,
    parameter int unsigned DWELL      = 1000,
    parameter int unsigned GAP        = 2000,
    parameter int unsigned CNT_W      = 11
) (
    input  logic                i_clk,
    input  logic                i_rst,
    grey_digit_scan_if.slave    bus
);

    localparam int unsigned VEC_W = DIGIT_W * NUM_DIGITS;
    localparam logic [CNT_W-1:0] DWELL_LD = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP - 1);
    localparam logic [3:0]       IDX_TOP  = 4'(NUM_DIGITS - 1);

    scan_state_e        state_q, state_d;
    logic [3:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   shadow_q, shadow_d;
    logic [7:0]         seg_q, seg_d;
    logic [3:0]         oidx_q, oidx_d;
    logic               frame_q, frame_d;

    logic [DIGIT_W-1:0] cur_code;
    logic [6:0]         dec_seg;
    logic               dp_show;
    logic               dp_gap;

    // Select the shadowed digit addressed by idx_q
    always_comb begin
        cur_code = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 4'(i)) begin
                cur_code = shadow_q[i*DIGIT_W +: DIGIT_W];
            end
        end
    end

    grey_seg_dec u_dec (
        .code_i (cur_code),
        .seg_o  (dec_seg)
    );

    // Decimal-point policy
    always_comb begin
`ifdef GREY_SCAN_DP_EN
        dp_show = (idx_q == 4'd3) || (idx_q == 4'd6) || (idx_q == 4'd9);
        dp_gap  = 1'b1;
`else
        dp_show = 1'b0;
        dp_gap  = 1'b0;
`endif
    end

    // Scan FSM next state, digit index, dwell/gap counter and snapshot
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        case (state_q)
            StIdle: begin
                if (bus.i_en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                shadow_d = bus.i_digits;
                idx_d    = IDX_TOP;
                state_d  = StSkip;
            end
            StSkip: begin
                // Ones digit is always shown, even when zero
                if (cur_code == JC_0 && idx_q != 4'd0) begin
                    idx_d = idx_q - 4'd1;
                end else begin
                    cnt_d   = DWELL_LD;
                    state_d = StShow;
                end
            end
            StShow: begin
                if (cnt_q == '0) begin
                    if (idx_q == 4'd0) begin
                        cnt_d   = GAP_LD;
                        state_d = StGap;
                    end else begin
                        idx_d = idx_q - 4'd1;
                        cnt_d = DWELL_LD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            StGap: begin
                if (cnt_q == '0) begin
                    state_d = bus.i_en ? StLoad : StIdle;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Registered outputs trail the FSM by one cycle
    always_comb begin
        seg_d   = 8'h00;
        oidx_d  = 4'd0;
        frame_d = (state_q == StLoad);
        if (state_q == StShow) begin
            seg_d  = {dp_show, dec_seg};
            oidx_d = idx_q;
        end else if (state_q == StGap) begin
            seg_d = {dp_gap, 7'h00};
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= StIdle;
            idx_q    <= 4'd0;
            cnt_q    <= '0;
            shadow_q <= '0;
            seg_q    <= 8'h00;
            oidx_q   <= 4'd0;
            frame_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            seg_q    <= seg_d;
            oidx_q   <= oidx_d;
            frame_q  <= frame_d;
        end
    end

    assign bus.o_seg   = seg_q;
    assign bus.o_idx   = oidx_q;
    assign bus.o_frame = frame_q;

endmodule
